// File: rtl/axi_rw_cmd_arbiter.sv
// Arbitrates write and read command beats onto a single MC command port.
// A granted requester holds the grant until its last beat is accepted by the MC.
`timescale 1ns/1ps
module axi_rw_cmd_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int C_RD_PRIORITY  = 0,
    parameter int C_STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_cmd_en,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic                  wr_cmd_last,
    output logic                  wr_cmd_full,
    input  logic                  rd_cmd_en,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                  rd_cmd_last,
    output logic                  rd_cmd_full,
    output logic                  mc_cmd_en,
    output logic [ADDR_WIDTH-1:0] mc_cmd_addr,
    output logic [2:0]            mc_cmd_instr,
    input  logic                  mc_cmd_full,
    output logic                  wr_gnt,
    output logic                  rd_gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_GNT = 2'd1,
        RD_GNT = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LIMIT = 8'(C_STARVE_LIMIT);

    state_t     state_reg, state_next;
    logic       last_rd_reg, last_rd_next;
    logic [7:0] starve_cnt_reg, starve_cnt_next;
    logic       beat_last;
    logic       accept;
    logic       arbitrate;
    logic       tie_to_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_rd_reg    <= 1'b1;
            starve_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            last_rd_reg    <= last_rd_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_rd_next    = last_rd_reg;
        starve_cnt_next = starve_cnt_reg;
        mc_cmd_en       = 1'b0;
        mc_cmd_addr     = '0;
        mc_cmd_instr    = 3'b000;
        wr_cmd_full     = 1'b1;
        rd_cmd_full     = 1'b1;
        beat_last       = 1'b0;

        case (state_reg)
            WR_GNT: begin
                mc_cmd_en   = wr_cmd_en;
                mc_cmd_addr = wr_cmd_addr;
                wr_cmd_full = mc_cmd_full;
                beat_last   = wr_cmd_last;
            end
            RD_GNT: begin
                mc_cmd_en    = rd_cmd_en;
                mc_cmd_addr  = rd_cmd_addr;
                mc_cmd_instr = 3'b001;
                rd_cmd_full  = mc_cmd_full;
                beat_last    = rd_cmd_last;
            end
            default: ;
        endcase

        accept    = mc_cmd_en & ~mc_cmd_full;
        arbitrate = (state_reg == IDLE) | (accept & beat_last);

        // Tie-break: round-robin uses the last grant, read-priority yields only to a starved write.
        if (C_RD_PRIORITY != 0) tie_to_wr = (starve_cnt_reg == STARVE_LIMIT);
        else                    tie_to_wr = last_rd_reg;

        if (arbitrate) begin
            if (wr_cmd_en && (!rd_cmd_en || tie_to_wr)) begin
                state_next   = WR_GNT;
                last_rd_next = 1'b0;
            end else if (rd_cmd_en) begin
                state_next   = RD_GNT;
                last_rd_next = 1'b1;
            end else begin
                state_next   = IDLE;
            end
        end

        if (C_RD_PRIORITY != 0) begin
            if (state_next == WR_GNT)
                starve_cnt_next = 8'd0;
            else if (wr_cmd_en && (state_reg != WR_GNT) && (starve_cnt_reg < STARVE_LIMIT))
                starve_cnt_next = starve_cnt_reg + 8'd1;
        end else begin
            starve_cnt_next = 8'd0;
        end
    end

    assign wr_gnt = (state_reg == WR_GNT);
    assign rd_gnt = (state_reg == RD_GNT);

endmodule

// File: tb/tb_axi_rw_cmd_arbiter.sv
// Bench for axi_rw_cmd_arbiter: round-robin and read-priority instances on shared stimulus,
// checked against directed vectors and a grant-owner reference model.
`timescale 1ns/1ps
module tb_axi_rw_cmd_arbiter;

    localparam int AW    = 28;
    localparam int LIMIT = 4;
    localparam int NONE  = 0;
    localparam int WR    = 1;
    localparam int RD    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wr_cmd_en, wr_cmd_last, rd_cmd_en, rd_cmd_last, mc_cmd_full;
    logic [AW-1:0] wr_cmd_addr, rd_cmd_addr;

    logic          a_wr_full, a_rd_full, a_mc_en, a_wr_gnt, a_rd_gnt;
    logic [AW-1:0] a_mc_addr;
    logic [2:0]    a_mc_instr;
    logic          b_wr_full, b_rd_full, b_mc_en, b_wr_gnt, b_rd_gnt;
    logic [AW-1:0] b_mc_addr;
    logic [2:0]    b_mc_instr;

    axi_rw_cmd_arbiter #(.ADDR_WIDTH(AW), .C_RD_PRIORITY(0), .C_STARVE_LIMIT(16)) dut_a (
        .clk(clk), .reset(reset),
        .wr_cmd_en(wr_cmd_en), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_last(wr_cmd_last), .wr_cmd_full(a_wr_full),
        .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_last(rd_cmd_last), .rd_cmd_full(a_rd_full),
        .mc_cmd_en(a_mc_en), .mc_cmd_addr(a_mc_addr), .mc_cmd_instr(a_mc_instr), .mc_cmd_full(mc_cmd_full),
        .wr_gnt(a_wr_gnt), .rd_gnt(a_rd_gnt)
    );

    axi_rw_cmd_arbiter #(.ADDR_WIDTH(AW), .C_RD_PRIORITY(1), .C_STARVE_LIMIT(LIMIT)) dut_b (
        .clk(clk), .reset(reset),
        .wr_cmd_en(wr_cmd_en), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_last(wr_cmd_last), .wr_cmd_full(b_wr_full),
        .rd_cmd_en(rd_cmd_en), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_last(rd_cmd_last), .rd_cmd_full(b_rd_full),
        .mc_cmd_en(b_mc_en), .mc_cmd_addr(b_mc_addr), .mc_cmd_instr(b_mc_instr), .mc_cmd_full(mc_cmd_full),
        .wr_gnt(b_wr_gnt), .rd_gnt(b_rd_gnt)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: who owns the MC port, who was granted last, how long a write has waited.
    int m_owner [2];
    bit m_last_rd [2];
    int m_starve [2];

    typedef struct {
        logic        rst, we, wl;
        logic [15:0] wa;
        logic        re, rl;
        logic [15:0] ra;
        logic        mf;
        logic [1:0]  gnt;
        logic        men;
        logic [2:0]  instr;
        logic [15:0] addr;
        logic        wf, rf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic we, input logic wl, input logic [15:0] wa,
                       input logic re, input logic rl, input logic [15:0] ra, input logic mf,
                       input logic [1:0] gnt, input logic men, input logic [2:0] instr,
                       input logic [15:0] addr, input logic wf, input logic rf);
        vec_t v;
        v.rst = rst; v.we = we; v.wl = wl; v.wa = wa; v.re = re; v.rl = rl; v.ra = ra; v.mf = mf;
        v.gnt = gnt; v.men = men; v.instr = instr; v.addr = addr; v.wf = wf; v.rf = rf;
        tbl.push_back(v);
    endtask

    function automatic logic [35:0] dut_out(input int c);
        if (c == 0) return {a_wr_gnt, a_rd_gnt, a_mc_en, a_mc_instr, a_wr_full, a_rd_full, a_mc_addr};
        return {b_wr_gnt, b_rd_gnt, b_mc_en, b_mc_instr, b_wr_full, b_rd_full, b_mc_addr};
    endfunction

    function automatic logic [35:0] model_out(input int c);
        logic          gw, gr, men, wf, rf;
        logic [2:0]    ins;
        logic [AW-1:0] ad;
        gw  = (m_owner[c] == WR);
        gr  = (m_owner[c] == RD);
        men = gw ? wr_cmd_en : (gr ? rd_cmd_en : 1'b0);
        ins = gr ? 3'b001 : 3'b000;
        ad  = gw ? wr_cmd_addr : (gr ? rd_cmd_addr : '0);
        wf  = gw ? mc_cmd_full : 1'b1;
        rf  = gr ? mc_cmd_full : 1'b1;
        return {gw, gr, men, ins, wf, rf, ad};
    endfunction

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            int o;
            int nxt;
            bit beat;
            bit done;
            bit wr_wins;
            o = m_owner[c];
            if (reset) begin
                m_owner[c]   = NONE;
                m_last_rd[c] = 1'b1;
                m_starve[c]  = 0;
                continue;
            end
            beat = (o == WR && wr_cmd_en) || (o == RD && rd_cmd_en);
            done = beat && !mc_cmd_full && ((o == WR) ? wr_cmd_last : rd_cmd_last);
            nxt  = o;
            if (o == NONE || done) begin
                if (wr_cmd_en && rd_cmd_en) begin
                    wr_wins = (c == 0) ? m_last_rd[c] : (m_starve[c] == LIMIT);
                    nxt = wr_wins ? WR : RD;
                end else if (wr_cmd_en) nxt = WR;
                else if (rd_cmd_en)     nxt = RD;
                else                    nxt = NONE;
                if (nxt != NONE) m_last_rd[c] = (nxt == RD);
            end
            if (c == 1) begin
                if (nxt == WR)                  m_starve[c] = 0;
                else if (wr_cmd_en && o != WR)  m_starve[c] = (m_starve[c] + 1 > LIMIT) ? LIMIT : m_starve[c] + 1;
            end
            m_owner[c] = nxt;
        end
    endtask

    task automatic check_model();
        for (int c = 0; c < 2; c++) begin
            logic [35:0] got;
            logic [35:0] exp;
            got = dut_out(c);
            exp = model_out(c);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL model_cfg%0d t=%0t got=%h exp=%h (gnt,en,instr,wf,rf,addr)", c, $time, got, exp);
            end
        end
    endtask

    task automatic sample();
        #4;
        check_model();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    bit [1:0] starve_exp [12];

    initial begin
        reset = 1'b1;
        wr_cmd_en = 1'b0; wr_cmd_last = 1'b0; wr_cmd_addr = '0;
        rd_cmd_en = 1'b0; rd_cmd_last = 1'b0; rd_cmd_addr = '0;
        mc_cmd_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            m_owner[c] = NONE; m_last_rd[c] = 1'b1; m_starve[c] = 0;
        end

        // Directed vectors for the round-robin instance: rst we wl wa re rl ra mf | gnt en instr addr wf rf
        add(1,0,0,16'h000,0,0,16'h000,0, 2'b00,0,3'd0,16'h000,1,1);
        add(0,1,1,16'h100,0,0,16'h000,0, 2'b00,0,3'd0,16'h000,1,1);
        add(0,1,1,16'h100,0,0,16'h000,0, 2'b10,1,3'd0,16'h100,0,1);
        add(0,0,1,16'h100,0,0,16'h000,0, 2'b10,0,3'd0,16'h100,0,1);
        add(0,1,1,16'h200,1,1,16'h300,0, 2'b10,1,3'd0,16'h200,0,1);
        add(0,1,1,16'h200,1,1,16'h300,0, 2'b01,1,3'd1,16'h300,1,0);
        add(0,1,1,16'h200,1,1,16'h300,0, 2'b10,1,3'd0,16'h200,0,1);
        add(0,1,1,16'h200,1,1,16'h300,0, 2'b01,1,3'd1,16'h300,1,0);
        add(0,1,0,16'h400,0,0,16'h500,0, 2'b10,1,3'd0,16'h400,0,1);
        add(0,1,0,16'h404,1,1,16'h500,0, 2'b10,1,3'd0,16'h404,0,1);
        add(0,1,0,16'h408,1,1,16'h500,0, 2'b10,1,3'd0,16'h408,0,1);
        add(0,1,1,16'h40c,1,1,16'h500,0, 2'b10,1,3'd0,16'h40c,0,1);
        add(0,1,0,16'h600,1,1,16'h500,0, 2'b01,1,3'd1,16'h500,1,0);
        for (int k = 0; k < 5; k++)
            add(0,1,1,16'h600,0,0,16'h500,1, 2'b10,1,3'd0,16'h600,1,1);
        add(0,1,1,16'h600,0,0,16'h500,0, 2'b10,1,3'd0,16'h600,0,1);
        add(0,1,0,16'h700,0,0,16'h000,0, 2'b10,1,3'd0,16'h700,0,1);
        add(1,1,0,16'h704,0,0,16'h000,0, 2'b10,1,3'd0,16'h704,0,1);
        add(0,0,0,16'h708,0,0,16'h000,0, 2'b00,0,3'd0,16'h000,1,1);
        add(0,0,0,16'h000,0,0,16'h000,0, 2'b00,0,3'd0,16'h000,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            logic [35:0] exp;
            logic [35:0] got;
            reset       = tbl[i].rst;
            wr_cmd_en   = tbl[i].we;  wr_cmd_last = tbl[i].wl; wr_cmd_addr = AW'(tbl[i].wa);
            rd_cmd_en   = tbl[i].re;  rd_cmd_last = tbl[i].rl; rd_cmd_addr = AW'(tbl[i].ra);
            mc_cmd_full = tbl[i].mf;
            sample();
            exp = {tbl[i].gnt, tbl[i].men, tbl[i].instr, tbl[i].wf, tbl[i].rf, AW'(tbl[i].addr)};
            got = dut_out(0);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL table[%0d] got=%h exp=%h", i, got, exp);
            end
            finish_cycle();
        end

        // Starvation on the read-priority instance: reads stream, a write waits LIMIT tie-losses.
        starve_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                       2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        reset = 1'b1; wr_cmd_en = 1'b0; rd_cmd_en = 1'b0; mc_cmd_full = 1'b0;
        sample();
        finish_cycle();
        reset = 1'b0;
        wr_cmd_en = 1'b1; wr_cmd_last = 1'b1; wr_cmd_addr = AW'(28'h0ABC000);
        rd_cmd_en = 1'b1; rd_cmd_last = 1'b1; rd_cmd_addr = AW'(28'h0DEF000);
        for (int i = 0; i < 12; i++) begin
            sample();
            vectors++;
            if ({b_wr_gnt, b_rd_gnt} !== starve_exp[i]) begin
                miscompares++;
                $display("FAIL starve_gnt[%0d] got=%b exp=%b", i, {b_wr_gnt, b_rd_gnt}, starve_exp[i]);
            end
            finish_cycle();
        end

        // Randomized traffic with occasional reset and MC back-pressure.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            wr_cmd_en   = ($urandom_range(0, 3) != 0);
            wr_cmd_last = ($urandom_range(0, 2) == 0);
            wr_cmd_addr = AW'($urandom);
            rd_cmd_en   = ($urandom_range(0, 3) != 0);
            rd_cmd_last = ($urandom_range(0, 2) == 0);
            rd_cmd_addr = AW'($urandom);
            mc_cmd_full = ($urandom_range(0, 3) == 0);
            sample();
            finish_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_rw_cmd_arbiter.md
AXI_RW_CMD_ARBITER -- requirements
Module: axi_rw_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 28, giving the MC command address width in bits.
REQ-002 The block SHALL have parameter C_RD_PRIORITY, default 0: 0 = round-robin, 1 = read-priority with write starvation guard.
REQ-003 The block SHALL have parameter C_STARVE_LIMIT, default 16, giving the write-wait cycles before a forced write grant (range 1..255).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 wr_cmd_en  input  1  write command FSM request, valid for one MC beat.
REQ-007 wr_cmd_addr  input  ADDR_WIDTH  write beat address.
REQ-008 wr_cmd_last  input  1  write beat is last of its AXI transaction.
REQ-009 wr_cmd_full  output  1  back-pressure to write FSM.
REQ-010 rd_cmd_en, rd_cmd_addr, rd_cmd_last, rd_cmd_full: same widths, directions and meanings as REQ-006..009, for the read FSM.
REQ-011 mc_cmd_en  output  1  command valid to MC.
REQ-012 mc_cmd_addr  output  ADDR_WIDTH  command address to MC.
REQ-013 mc_cmd_instr  output  3  3'b000 write, 3'b001 read.
REQ-014 mc_cmd_full  input  1  MC cannot accept command this cycle.
REQ-015 wr_gnt, rd_gnt  output  1 each  current grant status, one-hot or both 0.

Function
REQ-016 The FSM SHALL have states IDLE, WR_GNT and RD_GNT, held in registers; wr_gnt = (state==WR_GNT), rd_gnt = (state==RD_GNT).
REQ-017 In IDLE: mc_cmd_en = 0; wr_cmd_full = rd_cmd_full = 1; mc_cmd_addr = 0; mc_cmd_instr = 3'b000.
REQ-018 In WR_GNT: mc_cmd_en = wr_cmd_en; mc_cmd_addr = wr_cmd_addr; mc_cmd_instr = 3'b000; wr_cmd_full = mc_cmd_full; rd_cmd_full = 1. RD_GNT mirrors this for read with instr 3'b001. All combinational, zero latency.
REQ-019 A beat SHALL be accepted when mc_cmd_en & ~mc_cmd_full; only accepted beats affect the FSM.
REQ-020 Grant lock: a granted requester SHALL keep the grant until its beat with *_cmd_last=1 is accepted; the other requester's request SHALL NOT preempt it.
REQ-021 Arbitration SHALL occur in IDLE and in the cycle a last beat is accepted; the winner's state is entered next cycle; with no request the next state is IDLE.
REQ-022 The arbitration result SHALL be registered, giving one cycle of latency from request in IDLE to mc_cmd_en.
REQ-023 Round-robin (C_RD_PRIORITY=0): a single requester wins; with both requesting, the one not last granted wins. The last_granted register SHALL reset to read, so write wins the first tie.
REQ-024 Read-priority (C_RD_PRIORITY=1): read wins ties unless starve_cnt == C_STARVE_LIMIT, in which case write wins.
REQ-025 starve_cnt SHALL be 8 bits. It SHALL increment each cycle wr_cmd_en=1 and state!=WR_GNT, saturate at C_STARVE_LIMIT, and clear to 0 on entry to WR_GNT. It SHALL be unused (held 0) when C_RD_PRIORITY=0.
REQ-026 Back-to-back: when a last beat is accepted and the other requester is requesting, the grant SHALL switch with no IDLE cycle.
REQ-027 When a last beat is accepted and only the same requester is requesting, it SHALL be re-granted with no IDLE cycle.
REQ-028 mc_cmd_full held high SHALL freeze the state; addr/instr track the granted requester's inputs.
REQ-029 Requester deasserting *_cmd_en mid-transaction SHALL NOT release the grant.

Reset
REQ-030 While reset=1, the next state SHALL be IDLE, last_granted = read and starve_cnt = 0; after the edge, all outputs take IDLE values per REQ-017.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; no beat is replayed after reset.

Verification
REQ-032 Single write: wr_cmd_en=1, last=1, addr=0x100, mc_cmd_full=0 from IDLE -> mc_cmd_en=1, instr=000, addr=0x100 on cycle 2; state IDLE on cycle 3.
REQ-033 Tie, RR: wr and rd both request 1-beat transactions continuously -> grants alternate W,R,W,R with no IDLE cycles between them.
REQ-034 Lock: write 4 beats (last on beat 4), rd_cmd_en raised after beat 1 -> all 4 write beats issue before any read; rd_cmd_full=1 throughout.
REQ-035 Back-pressure: mc_cmd_full=1 for 5 cycles during a write grant -> mc_cmd_en stays 1, wr_cmd_full=1, no state change; beat accepted on the first cycle with full=0.
REQ-036 Starvation, C_RD_PRIORITY=1, C_STARVE_LIMIT=4: continuous 1-beat reads plus a waiting write -> write granted at the first arbitration after starve_cnt reaches 4; starve_cnt returns to 0.
REQ-037 Reset mid-grant during beat 2 of 4 -> cycle after the reset edge: mc_cmd_en=0, both *_cmd_full=1, wr_gnt=rd_gnt=0.
